// File: rtl/fetchflare_pref_issue_queue.sv
// rtl/fetchflare_pref_issue_queue.sv - per-stream prefetch FIFOs feeding one issue register
// Optional duplicate-address suppression on push: FETCHFLARE_PREF_DEDUP_EN.
module fetchflare_pref_issue_queue #(
  parameter int NUM_STREAMS = 4,
  parameter int ADDR_WIDTH  = 40,
  parameter int DEPTH       = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [NUM_STREAMS-1:0]          push_valid_i,
  input  logic [NUM_STREAMS*ADDR_WIDTH-1:0] push_addr_i,
  output logic [NUM_STREAMS-1:0]          push_ready_o,
  input  logic [NUM_STREAMS-1:0]          flush_i,
  output logic [NUM_STREAMS-1:0]          arb_request_o,
  input  logic [NUM_STREAMS-1:0]          arb_grant_i,
  input  logic                            arb_any_grant_i,
  output logic                            mem_req_valid_o,
  output logic [ADDR_WIDTH-1:0]           mem_req_addr_o,
  output logic [$clog2(NUM_STREAMS)-1:0]  mem_req_stream_o,
  input  logic                            mem_req_ready_i
);

  localparam int SW = $clog2(NUM_STREAMS);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;

  logic [PW-1:0]         wr_ptr_q [NUM_STREAMS];
  logic [PW-1:0]         wr_ptr_d [NUM_STREAMS];
  logic [PW-1:0]         rd_ptr_q [NUM_STREAMS];
  logic [PW-1:0]         rd_ptr_d [NUM_STREAMS];
  logic [ADDR_WIDTH-1:0] fifo_q   [NUM_STREAMS][DEPTH];

  logic [NUM_STREAMS-1:0] full;
  logic [NUM_STREAMS-1:0] empty;
  logic [NUM_STREAMS-1:0] push_acc;
  logic [NUM_STREAMS-1:0] push_dup;
  logic [NUM_STREAMS-1:0] push_store;
  logic [NUM_STREAMS-1:0] pop_vec;
  logic                   slot_free;
  logic                   pop_any;
  logic [SW-1:0]          pop_idx;
  logic [ADDR_WIDTH-1:0]  pop_addr;

  logic                   mem_req_valid_q;
  logic [ADDR_WIDTH-1:0]  mem_req_addr_q;
  logic [SW-1:0]          mem_req_stream_q;

  assign slot_free = !mem_req_valid_q | mem_req_ready_i;

  always_comb begin
    for (int s = 0; s < NUM_STREAMS; s++) begin
      full[s]  = (wr_ptr_q[s][PW-1] != rd_ptr_q[s][PW-1]) &&
                 (wr_ptr_q[s][AW-1:0] == rd_ptr_q[s][AW-1:0]);
      empty[s] = (wr_ptr_q[s] == rd_ptr_q[s]);
      push_ready_o[s]  = !full[s];
      arb_request_o[s] = !empty[s] && !flush_i[s] && slot_free;
      push_acc[s] = push_valid_i[s] && !full[s] && !flush_i[s];
    end
  end

`ifdef FETCHFLARE_PREF_DEDUP_EN
  // Compare against every occupied slot, including a head popped this cycle.
  always_comb begin
    for (int s = 0; s < NUM_STREAMS; s++) begin
      logic [AW-1:0] offset;
      logic [PW-1:0] count;
      push_dup[s] = 1'b0;
      count = wr_ptr_q[s] - rd_ptr_q[s];
      for (int k = 0; k < DEPTH; k++) begin
        offset = AW'(k) - rd_ptr_q[s][AW-1:0];
        if (({1'b0, offset} < count) &&
            (fifo_q[s][k] == push_addr_i[s*ADDR_WIDTH +: ADDR_WIDTH]))
          push_dup[s] = 1'b1;
      end
    end
  end
`else
  assign push_dup = '0;
`endif

  assign push_store = push_acc & ~push_dup;
  assign pop_vec    = arb_grant_i & arb_request_o & {NUM_STREAMS{arb_any_grant_i}};
  assign pop_any    = |pop_vec;

  always_comb begin
    pop_idx  = '0;
    pop_addr = '0;
    for (int s = 0; s < NUM_STREAMS; s++) begin
      if (pop_vec[s]) begin
        pop_idx  = SW'(s);
        pop_addr = fifo_q[s][rd_ptr_q[s][AW-1:0]];
      end
    end
  end

  // Flush discards everything queued, so the read side jumps to the write side.
  always_comb begin
    for (int s = 0; s < NUM_STREAMS; s++) begin
      wr_ptr_d[s] = wr_ptr_q[s] + PW'(push_store[s]);
      rd_ptr_d[s] = flush_i[s] ? wr_ptr_q[s] : rd_ptr_q[s] + PW'(pop_vec[s]);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int s = 0; s < NUM_STREAMS; s++) begin
        wr_ptr_q[s] <= '0;
        rd_ptr_q[s] <= '0;
      end
      mem_req_valid_q  <= 1'b0;
      mem_req_addr_q   <= '0;
      mem_req_stream_q <= '0;
    end else begin
      for (int s = 0; s < NUM_STREAMS; s++) begin
        wr_ptr_q[s] <= wr_ptr_d[s];
        rd_ptr_q[s] <= rd_ptr_d[s];
      end
      if (pop_any) begin
        mem_req_valid_q  <= 1'b1;
        mem_req_addr_q   <= pop_addr;
        mem_req_stream_q <= pop_idx;
      end else if (mem_req_ready_i) begin
        mem_req_valid_q  <= 1'b0;
      end
    end
  end

  // Entry storage needs no reset: occupancy is defined by the pointers alone.
  always_ff @(posedge clk) begin
    for (int s = 0; s < NUM_STREAMS; s++) begin
      if (push_store[s])
        fifo_q[s][wr_ptr_q[s][AW-1:0]] <= push_addr_i[s*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    if (reset && arb_any_grant_i)
      assert ($onehot(arb_grant_i)) else $error("arb_grant_i is not one-hot");
  end

  assign mem_req_valid_o  = mem_req_valid_q;
  assign mem_req_addr_o   = mem_req_addr_q;
  assign mem_req_stream_o = mem_req_stream_q;

endmodule

// File: tb/tb_fetchflare_pref_issue_queue.sv
// tb/tb_fetchflare_pref_issue_queue.sv - scoreboard bench with a round-robin arbiter model
module tb_fetchflare_pref_issue_queue;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [3:0]   push_valid_i = '0;
  logic [159:0] push_addr_i = '0;
  logic [3:0]   push_ready_o;
  logic [3:0]   flush_i = '0;
  logic [3:0]   arb_request_o;
  logic [3:0]   arb_grant_i;
  logic         arb_any_grant_i;
  logic         mem_req_valid_o;
  logic [39:0]  mem_req_addr_o;
  logic [1:0]   mem_req_stream_o;
  logic         mem_req_ready_i = 1'b0;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [39:0] addr;
    logic [1:0]  s;
  } exp_t;
  exp_t sb[$];

  fetchflare_pref_issue_queue dut (
    .clk              (clk),
    .reset            (reset),
    .push_valid_i     (push_valid_i),
    .push_addr_i      (push_addr_i),
    .push_ready_o     (push_ready_o),
    .flush_i          (flush_i),
    .arb_request_o    (arb_request_o),
    .arb_grant_i      (arb_grant_i),
    .arb_any_grant_i  (arb_any_grant_i),
    .mem_req_valid_o  (mem_req_valid_o),
    .mem_req_addr_o   (mem_req_addr_o),
    .mem_req_stream_o (mem_req_stream_o),
    .mem_req_ready_i  (mem_req_ready_i)
  );

  always #5 clk = ~clk;

  // Round-robin arbiter model, with an override to force arbitrary grants
  logic       arb_en = 1'b0;
  logic       force_en = 1'b0;
  logic [3:0] force_grant = '0;
  logic [1:0] arb_ptr_q;
  logic [1:0] gidx;

  always_comb begin
    arb_grant_i = '0;
    gidx = '0;
    if (force_en) begin
      arb_grant_i = force_grant;
    end else if (arb_en) begin
      for (int off = 0; off < 4; off++) begin
        if (arb_grant_i == 4'b0 && arb_request_o[2'(arb_ptr_q + 2'(off))]) begin
          arb_grant_i[2'(arb_ptr_q + 2'(off))] = 1'b1;
          gidx = 2'(arb_ptr_q + 2'(off));
        end
      end
    end
    arb_any_grant_i = |arb_grant_i;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) arb_ptr_q <= '0;
    else if (!force_en && |arb_grant_i) arb_ptr_q <= gidx + 2'd1;
  end

  always @(negedge clk) begin
    if (reset && mem_req_valid_o && mem_req_ready_i) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_issue: got addr=%h stream=%0d, expected none", mem_req_addr_o, mem_req_stream_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (mem_req_addr_o !== e.addr || mem_req_stream_o !== e.s) begin
          errors++;
          $display("FAIL issue_order: got addr=%h stream=%0d, expected addr=%h stream=%0d",
                   mem_req_addr_o, mem_req_stream_o, e.addr, e.s);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    push_valid_i = '0;
    flush_i = '0;
    arb_en = 1'b0;
    force_en = 1'b0;
    mem_req_ready_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic push_one(input int s, input logic [39:0] a, input bit expect_issue);
    bit ok = 0;
    push_valid_i[s] = 1'b1;
    push_addr_i[s*40 +: 40] = a;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (push_ready_o[s]) ok = 1;
      cyc();
      if (ok) break;
    end
    push_valid_i[s] = 1'b0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL push_accept: stream %0d addr %h not accepted, expected accept", s, a);
    end else if (expect_issue) begin
      sb.push_back('{addr: a, s: 2'(s)});
    end
  endtask

  task automatic wait_drain(input string name);
    bit ok = 0;
    arb_en = 1'b1;
    mem_req_ready_i = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && !mem_req_valid_o) ok = 1;
      cyc();
      if (ok) break;
    end
    repeat (4) cyc();
    checks++;
    if (!ok || sb.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d issues outstanding, expected 0", name, sb.size());
    end
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks += 5;
    if (push_ready_o !== 4'hF) begin errors++; $display("FAIL reset_push_ready: got %b, expected 1111", push_ready_o); end
    if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", mem_req_valid_o); end
    if (mem_req_addr_o !== 40'h0) begin errors++; $display("FAIL reset_addr: got %h, expected 0", mem_req_addr_o); end
    if (mem_req_stream_o !== 2'd0) begin errors++; $display("FAIL reset_stream: got %0d, expected 0", mem_req_stream_o); end
    if (arb_request_o !== 4'h0) begin errors++; $display("FAIL reset_request: got %b, expected 0000", arb_request_o); end
    cyc();
  endtask

  task automatic test_latency();
    arb_en = 1'b1;
    mem_req_ready_i = 1'b1;
    push_valid_i[2] = 1'b1;
    push_addr_i[2*40 +: 40] = 40'h1000;
    sb.push_back('{addr: 40'h1000, s: 2'd2});
    cyc();
    push_valid_i[2] = 1'b0;
    @(negedge clk);
    checks++;
    if (arb_request_o !== 4'b0100) begin errors++; $display("FAIL latency_request: got %b, expected 0100", arb_request_o); end
    cyc();
    @(negedge clk);
    checks += 3;
    if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL latency_valid: got %b, expected 1", mem_req_valid_o); end
    if (mem_req_addr_o !== 40'h1000) begin errors++; $display("FAIL latency_addr: got %h, expected 1000", mem_req_addr_o); end
    if (mem_req_stream_o !== 2'd2) begin errors++; $display("FAIL latency_stream: got %0d, expected 2", mem_req_stream_o); end
    cyc();
    wait_drain("latency");
  endtask

  task automatic test_full();
    arb_en = 1'b0;
    mem_req_ready_i = 1'b1;
    push_one(0, 40'h40, 1);
    push_one(0, 40'h80, 1);
    push_valid_i[0] = 1'b1;
    push_addr_i[0 +: 40] = 40'hC0;
    repeat (3) begin
      @(negedge clk);
      checks++;
      if (push_ready_o[0] !== 1'b0) begin errors++; $display("FAIL full_ready: got %b, expected 0", push_ready_o[0]); end
      cyc();
    end
    arb_en = 1'b1;
    push_one(0, 40'hC0, 1);
    wait_drain("full");
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_valid_i = 4'hF;
    for (int s = 0; s < 4; s++) begin
      push_addr_i[s*40 +: 40] = 40'hA00 + 40'(s * 'h40);
      sb.push_back('{addr: 40'hA00 + 40'(s * 'h40), s: 2'(s)});
    end
    cyc();
    push_valid_i = '0;
    arb_en = 1'b1;
    cyc();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks += 4;
      if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b, expected 1", i, mem_req_valid_o); end
      if (mem_req_addr_o !== 40'hA00) begin errors++; $display("FAIL stall_addr[%0d]: got %h, expected a00", i, mem_req_addr_o); end
      if (mem_req_stream_o !== 2'd0) begin errors++; $display("FAIL stall_stream[%0d]: got %0d, expected 0", i, mem_req_stream_o); end
      if (arb_request_o !== 4'h0) begin errors++; $display("FAIL stall_request[%0d]: got %b, expected 0000", i, arb_request_o); end
      cyc();
    end
    mem_req_ready_i = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks += 2;
      if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %b, expected 1", k, mem_req_valid_o); end
      if (mem_req_stream_o !== 2'(k)) begin errors++; $display("FAIL b2b_stream[%0d]: got %0d, expected %0d", k, mem_req_stream_o, k); end
      cyc();
    end
    wait_drain("b2b");
  endtask

  task automatic test_flush();
    arb_en = 1'b1;
    mem_req_ready_i = 1'b0;
    push_one(2, 40'h2A0, 1);
    repeat (2) cyc();
    push_one(1, 40'h100, 0);
    push_one(1, 40'h180, 0);
    @(negedge clk);
    checks++;
    if (push_ready_o[1] !== 1'b0) begin errors++; $display("FAIL flush_prefull: got %b, expected 0", push_ready_o[1]); end
    cyc();
    flush_i[1] = 1'b1;
    push_valid_i[1] = 1'b1;
    push_addr_i[1*40 +: 40] = 40'h200;
    cyc();
    flush_i[1] = 1'b0;
    push_valid_i[1] = 1'b0;
    @(negedge clk);
    checks += 4;
    if (push_ready_o[1] !== 1'b1) begin errors++; $display("FAIL flush_ready: got %b, expected 1", push_ready_o[1]); end
    if (mem_req_valid_o !== 1'b1) begin errors++; $display("FAIL flush_out_valid: got %b, expected 1", mem_req_valid_o); end
    if (mem_req_addr_o !== 40'h2A0) begin errors++; $display("FAIL flush_out_addr: got %h, expected 2a0", mem_req_addr_o); end
    if (mem_req_stream_o !== 2'd2) begin errors++; $display("FAIL flush_out_stream: got %0d, expected 2", mem_req_stream_o); end
    cyc();
    mem_req_ready_i = 1'b1;
    @(negedge clk);
    checks++;
    if (arb_request_o !== 4'h0) begin errors++; $display("FAIL flush_empty_request: got %b, expected 0000", arb_request_o); end
    cyc();
    wait_drain("flush");
  endtask

  task automatic test_stray_grant();
    arb_en = 1'b0;
    force_en = 1'b1;
    force_grant = 4'b1000;
    mem_req_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks += 2;
      if (mem_req_valid_o !== 1'b0) begin errors++; $display("FAIL stray_valid[%0d]: got %b, expected 0", i, mem_req_valid_o); end
      if (arb_request_o !== 4'h0) begin errors++; $display("FAIL stray_request[%0d]: got %b, expected 0000", i, arb_request_o); end
      cyc();
    end
    force_en = 1'b0;
    @(negedge clk);
    checks++;
    if (push_ready_o !== 4'hF) begin errors++; $display("FAIL stray_ready: got %b, expected 1111", push_ready_o); end
    cyc();
    arb_en = 1'b1;
    push_one(3, 40'h3C0, 1);
    wait_drain("stray");
  endtask

  task automatic test_dedup();
    bit dedup;
`ifdef FETCHFLARE_PREF_DEDUP_EN
    dedup = 1;
`else
    dedup = 0;
`endif
    arb_en = 1'b0;
    mem_req_ready_i = 1'b1;
    push_one(0, 40'h300, 1);
    push_one(0, 40'h300, !dedup);
    @(negedge clk);
    checks++;
    if (push_ready_o[0] !== dedup) begin errors++; $display("FAIL dedup_occupancy: push_ready=%b, expected %b", push_ready_o[0], dedup); end
    cyc();
    wait_drain("dedup");
  endtask

  initial begin
    test_reset();
    test_latency();
    test_full();
    test_back_to_back();
    test_flush();
    test_stray_grant();
    test_dedup();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
